// File: rtl/thermal_encoder.sv
// thermal_encoder: pixel to thermometer-code input stage for the BNN core.
// Packs PACK codes per output beat and checks the frame length.
module thermal_encoder #(
    parameter int          LEVELS       = 8,
    parameter int          PACK         = 4,
    parameter int          FRAME_PIXELS = 784,
    parameter logic [7:0]  THR_BASE     = 8'h00,
    parameter logic [7:0]  ERR_CLR_ADDR = 8'h20
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             s_axis_tdata,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic                   s_axis_tlast,
    output logic [PACK*LEVELS-1:0] m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    input  logic                   reg_wr_en,
    input  logic [7:0]             reg_wr_addr,
    input  logic [31:0]            reg_wr_data,
    output logic                   err_len
);

    localparam int STEP = 256 / LEVELS;
    localparam int IW   = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int DW   = PACK * LEVELS;

    logic [7:0]        thr [LEVELS];
    logic [LEVELS-1:0] code;
    logic [DW-1:0]     acc;
    logic [DW-1:0]     placed;
    logic [IW-1:0]     idx;
    logic [15:0]       cnt;
    logic              accept;
    logic              flush;
    logic              len_bad;
    logic              err_clr;
    logic              unused_wr_bits;

    assign unused_wr_bits = ^reg_wr_data[31:8];

    assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
    assign accept  = s_axis_tvalid && s_axis_tready;
    assign flush   = (idx == IW'(PACK - 1)) || s_axis_tlast;
    assign len_bad = accept && s_axis_tlast &&
                     (cnt != 16'(FRAME_PIXELS - 1));
    assign err_clr = reg_wr_en && (reg_wr_addr == ERR_CLR_ADDR);

    // Each code bit is an independent compare against its own threshold
    always_comb begin
        code = '0;
        for (int k = 0; k < LEVELS; k++) begin
            code[k] = (s_axis_tdata >= thr[k]);
        end
    end

    // Steer the current code into the slot selected by idx
    always_comb begin
        placed = '0;
        for (int i = 0; i < PACK; i++) begin
            if (idx == IW'(i)) begin
                placed[i*LEVELS +: LEVELS] = code;
            end
        end
    end

    // Threshold register file: evenly spaced defaults, byte-wide writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < LEVELS; k++) begin
                thr[k] <= 8'(k * STEP + STEP / 2);
            end
        end else if (reg_wr_en) begin
            for (int k = 0; k < LEVELS; k++) begin
                if (int'(reg_wr_addr) == int'(THR_BASE) + k) begin
                    thr[k] <= reg_wr_data[7:0];
                end
            end
        end
    end

    // Pack accumulator and output beat register with valid/ready hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            idx           <= '0;
            acc           <= '0;
        end else begin
            if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            if (accept) begin
                if (flush) begin
                    m_axis_tdata  <= acc | placed;
                    m_axis_tvalid <= 1'b1;
                    m_axis_tlast  <= s_axis_tlast;
                    idx           <= '0;
                    acc           <= '0;
                end else begin
                    acc <= acc | placed;
                    idx <= idx + 1'b1;
                end
            end
        end
    end

    // Saturating pixel counter and sticky length error; a new error beats a clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            err_len <= 1'b0;
        end else begin
            if (accept) begin
                if (s_axis_tlast) begin
                    cnt <= '0;
                end else if (cnt != 16'hFFFF) begin
                    cnt <= cnt + 16'd1;
                end
            end
            if (len_bad) begin
                err_len <= 1'b1;
            end else if (err_clr) begin
                err_len <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_thermal_encoder.sv
// tb_thermal_encoder: directed bench for thermal_encoder.
// Beats are collected by a pre-edge monitor and checked per scenario.
module tb_thermal_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic        s_tlast = 1'b0;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic        m_tlast;
    logic        reg_wr_en = 1'b0;
    logic [7:0]  reg_wr_addr = '0;
    logic [31:0] reg_wr_data = '0;
    logic        err_len;

    int passed = 0;
    int total  = 0;
    int unstable = 0;
    int stall_seen = 0;
    bit hold_chk = 1'b0;
    logic [31:0] hold_d;
    logic hold_l;
    logic [31:0] bq[$];
    logic        lq[$];

    thermal_encoder #(
        .LEVELS(8), .PACK(4), .FRAME_PIXELS(784),
        .THR_BASE(8'h00), .ERR_CLR_ADDR(8'h20)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
        .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr),
        .reg_wr_data(reg_wr_data), .err_len(err_len)
    );

    always #5 clk = ~clk;

    // Sample just before each rising edge: collect beats, watch stalls
    always begin
        @(negedge clk);
        #4;
        if (!rst) begin
            if (hold_chk && m_tvalid &&
                (m_tdata !== hold_d || m_tlast !== hold_l)) begin
                unstable++;
            end
            hold_chk = m_tvalid && !m_tready;
            hold_d   = m_tdata;
            hold_l   = m_tlast;
            if (m_tvalid && m_tready) begin
                bq.push_back(m_tdata);
                lq.push_back(m_tlast);
            end
            if (s_tvalid && !s_tready) stall_seen++;
        end
    end

    task automatic send(input logic [7:0] p, input logic l,
                        input logic w = 1'b0,
                        input logic [7:0] wa = 8'h00,
                        input logic [31:0] wd = 32'h0);
        int n;
        @(negedge clk);
        s_tvalid = 1'b1;
        s_tdata  = p;
        s_tlast  = l;
        if (w) begin
            reg_wr_en   = 1'b1;
            reg_wr_addr = wa;
            reg_wr_data = wd;
        end
        n = 0;
        #4;
        while (!s_tready && n < 50) begin
            @(negedge clk);
            #4;
            n++;
        end
        if (!s_tready) begin
            total++;
            $display("FAIL send_timeout pixel=%02h got tready=0 need 1", p);
        end
        @(posedge clk);
        #1;
        reg_wr_en = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic drain();
        repeat (3) @(negedge clk);
    endtask

    task automatic wr_reg(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        reg_wr_en   = 1'b1;
        reg_wr_addr = a;
        reg_wr_data = d;
        @(negedge clk);
        reg_wr_en = 1'b0;
    endtask

    task automatic get_beat(output logic [31:0] d, output logic l);
        if (bq.size() > 0) begin
            d = bq.pop_front();
            l = lq.pop_front();
        end else begin
            d = 'x;
            l = 1'bx;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if (m_tvalid !== 1'b0) $display("FAIL rst_tvalid got %b need 0", m_tvalid);
        else passed++;
        total++;
        if (m_tdata !== 32'h0) $display("FAIL rst_tdata got %h need 0", m_tdata);
        else passed++;
        total++;
        if (m_tlast !== 1'b0) $display("FAIL rst_tlast got %b need 0", m_tlast);
        else passed++;
        total++;
        if (err_len !== 1'b0) $display("FAIL rst_err got %b need 0", err_len);
        else passed++;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (s_tready !== 1'b1) $display("FAIL rst_sready got %b need 1", s_tready);
        else passed++;
    endtask

    task automatic test_defaults();
        logic [31:0] d;
        logic l;
        send(8'd0, 1'b0);
        send(8'd16, 1'b0);
        send(8'd47, 1'b0);
        send(8'd255, 1'b1);
        idle();
        drain();
        total++;
        if (bq.size() !== 1) $display("FAIL def_beats got %0d need 1", bq.size());
        else passed++;
        get_beat(d, l);
        total++;
        if (d !== 32'hFF010100) $display("FAIL def_data got %h need ff010100", d);
        else passed++;
        total++;
        if (l !== 1'b1) $display("FAIL def_tlast got %b need 1", l);
        else passed++;
        total++;
        if (err_len !== 1'b1) $display("FAIL def_err got %b need 1", err_len);
        else passed++;
    endtask

    task automatic test_backpressure();
        logic [7:0] px [8] = '{8'd0, 8'd16, 8'd47, 8'd255,
                               8'd80, 8'd112, 8'd144, 8'd176};
        logic [31:0] d;
        logic l;
        wr_reg(8'h20, 32'h0);
        unstable   = 0;
        stall_seen = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) send(px[i], i == 7);
            end
            begin
                repeat (3) @(negedge clk);
                m_tready = 1'b0;
                repeat (5) @(negedge clk);
                m_tready = 1'b1;
            end
        join
        idle();
        drain();
        total++;
        if (bq.size() !== 2) $display("FAIL bp_beats got %0d need 2", bq.size());
        else passed++;
        get_beat(d, l);
        total++;
        if (d !== 32'hFF010100 || l !== 1'b0)
            $display("FAIL bp_beat1 got %h/%b need ff010100/0", d, l);
        else passed++;
        get_beat(d, l);
        total++;
        if (d !== 32'h3F1F0F07 || l !== 1'b1)
            $display("FAIL bp_beat2 got %h/%b need 3f1f0f07/1", d, l);
        else passed++;
        total++;
        if (stall_seen == 0) $display("FAIL bp_sready_drop got 0 stalls need >0");
        else passed++;
        total++;
        if (unstable !== 0) $display("FAIL bp_stable got %0d changes need 0", unstable);
        else passed++;
    endtask

    task automatic test_partial();
        logic [31:0] d;
        logic l;
        for (int i = 0; i < 6; i++) send(8'hFF, i == 5);
        idle();
        drain();
        total++;
        if (bq.size() !== 2) $display("FAIL part_beats got %0d need 2", bq.size());
        else passed++;
        get_beat(d, l);
        total++;
        if (d !== 32'hFFFFFFFF || l !== 1'b0)
            $display("FAIL part_beat1 got %h/%b need ffffffff/0", d, l);
        else passed++;
        get_beat(d, l);
        total++;
        if (d !== 32'h0000FFFF || l !== 1'b1)
            $display("FAIL part_beat2 got %h/%b need 0000ffff/1", d, l);
        else passed++;
    endtask

    task automatic test_threshold();
        logic [31:0] d;
        logic l;
        wr_reg(8'h00, 32'h80);
        send(8'h70, 1'b0);
        send(8'h80, 1'b0);
        send(8'hFF, 1'b0);
        send(8'h00, 1'b1);
        idle();
        drain();
        get_beat(d, l);
        total++;
        if (d !== 32'h00FF0F0E || l !== 1'b1)
            $display("FAIL thr_new got %h/%b need 00ff0f0e/1", d, l);
        else passed++;
        send(8'h00, 1'b0, 1'b1, 8'h01, 32'h0);
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        send(8'h00, 1'b1);
        idle();
        drain();
        get_beat(d, l);
        total++;
        if (d !== 32'h02020200)
            $display("FAIL thr_same_cycle got %h need 02020200", d);
        else passed++;
        wr_reg(8'h00, 32'd16);
        wr_reg(8'h01, 32'd48);
        wr_reg(8'h08, 32'h0);
        send(8'd16, 1'b0);
        send(8'd47, 1'b0);
        send(8'd0, 1'b0);
        send(8'd255, 1'b1);
        idle();
        drain();
        get_beat(d, l);
        total++;
        if (d !== 32'hFF000101)
            $display("FAIL thr_restore got %h need ff000101", d);
        else passed++;
    endtask

    task automatic test_length();
        logic [31:0] d;
        logic l;
        int bad_data;
        int bad_last;
        wr_reg(8'h20, 32'h0);
        total++;
        if (err_len !== 1'b0) $display("FAIL len_clr1 got %b need 0", err_len);
        else passed++;
        for (int i = 0; i < 10; i++) send(8'd48, i == 9);
        idle();
        drain();
        total++;
        if (bq.size() !== 3) $display("FAIL len10_beats got %0d need 3", bq.size());
        else passed++;
        get_beat(d, l);
        get_beat(d, l);
        get_beat(d, l);
        total++;
        if (d !== 32'h00000303 || l !== 1'b1)
            $display("FAIL len10_last got %h/%b need 00000303/1", d, l);
        else passed++;
        total++;
        if (err_len !== 1'b1) $display("FAIL len10_err got %b need 1", err_len);
        else passed++;
        repeat (5) @(negedge clk);
        total++;
        if (err_len !== 1'b1) $display("FAIL len_sticky got %b need 1", err_len);
        else passed++;
        send(8'h00, 1'b1, 1'b1, 8'h20, 32'h0);
        idle();
        drain();
        get_beat(d, l);
        total++;
        if (err_len !== 1'b1) $display("FAIL len_err_wins got %b need 1", err_len);
        else passed++;
        wr_reg(8'h20, 32'h0);
        total++;
        if (err_len !== 1'b0) $display("FAIL len_clr2 got %b need 0", err_len);
        else passed++;
        for (int i = 0; i < 784; i++) send(8'hFF, i == 783);
        idle();
        drain();
        total++;
        if (bq.size() !== 196) $display("FAIL len784_beats got %0d need 196", bq.size());
        else passed++;
        bad_data = 0;
        bad_last = 0;
        for (int j = 0; j < 196; j++) begin
            get_beat(d, l);
            if (d !== 32'hFFFFFFFF) bad_data++;
            if (l !== (j == 195)) bad_last++;
        end
        total++;
        if (bad_data !== 0 || bad_last !== 0)
            $display("FAIL len784_content got %0d/%0d bad need 0/0", bad_data, bad_last);
        else passed++;
        total++;
        if (err_len !== 1'b0) $display("FAIL len784_err got %b need 0", err_len);
        else passed++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic l;
        m_tready = 1'b0;
        send(8'd0, 1'b0);
        send(8'd16, 1'b0);
        send(8'd47, 1'b0);
        send(8'd255, 1'b0);
        idle();
        @(negedge clk);
        #1;
        total++;
        if (m_tvalid !== 1'b1) $display("FAIL rm_pending got %b need 1", m_tvalid);
        else passed++;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        total++;
        if (m_tvalid !== 1'b0 || m_tdata !== 32'h0 || m_tlast !== 1'b0)
            $display("FAIL rm_async got %b/%h/%b need 0/0/0", m_tvalid, m_tdata, m_tlast);
        else passed++;
        #1;
        rst = 1'b0;
        @(negedge clk);
        m_tready = 1'b1;
        send(8'd0, 1'b0);
        send(8'd16, 1'b0);
        send(8'd47, 1'b0);
        send(8'd255, 1'b1);
        idle();
        drain();
        total++;
        if (bq.size() !== 1) $display("FAIL rm_beats got %0d need 1", bq.size());
        else passed++;
        get_beat(d, l);
        total++;
        if (d !== 32'hFF010100 || l !== 1'b1)
            $display("FAIL rm_beat got %h/%b need ff010100/1", d, l);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_backpressure();
        test_partial();
        test_threshold();
        test_length();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
